// File: rtl/bitbrick_pkg.sv
// Shared definitions for the bitbrick sequential MAC: precision codes,
// FSM state type and the crumb-count helper.
package bitbrick_pkg;

  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of 2-bit crumbs per operand; the reserved code 11 behaves as 8b.
  function automatic logic [2:0] crumb_count(input logic [1:0] prec);
    logic [2:0] c;
    case (prec)
      PREC_2B: c = 3'd1;
      PREC_4B: c = 3'd2;
      default: c = 3'd4;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bitbrick.sv
// 2-bit x 2-bit multiplier brick; sel[1]/sel[0] mark a/b as two's complement.
// p is the 4-bit product, to be read as signed whenever sel is non-zero.
module bitbrick (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] sel,
  output logic [3:0] p
);

  logic signed [3:0] a_x;
  logic signed [3:0] b_x;
  logic signed [3:0] prod;

  // Every product of two 2-bit operands fits in 4 bits, so the low half is exact.
  assign a_x  = {{2{sel[1] & a[1]}}, a};
  assign b_x  = {{2{sel[0] & b[1]}}, b};
  assign prod = a_x * b_x;
  assign p    = prod;

endmodule

// File: rtl/bitbrick_seq_mac.sv
// Sequential 2/4/8-bit MAC that walks crumb pairs through one bitbrick.
// Define BITBRICK_SEQ_MAC_SAT_EN for saturating accumulation and a sticky sat_flag.
module bitbrick_seq_mac
  import bitbrick_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [1:0]       prec,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BITBRICK_SEQ_MAC_SAT_EN
  output logic             sat_flag,
`endif
  output logic [ACC_W-1:0] acc_out
);

  // Handshakes: a transfer happens on any rising edge where valid & ready are both high.
  state_e                   state_q, state_d;
  logic [7:0]               a_q, a_d, b_q, b_d;
  logic [1:0]               prec_q, prec_d;
  logic                     as_q, as_d, bs_q, bs_d, clr_q, clr_d;
  logic [1:0]               i_q, i_d, j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic [2:0]               c_cnt;
  logic [1:0]               last_idx;
  logic [1:0]               bb_a, bb_b, bb_sel;
  logic [3:0]               bb_p;
  logic [3:0]               shamt;
  logic signed [ACC_W-1:0]  p_ext, term, base, acc_next;
  logic                     clip;

  assign c_cnt    = crumb_count(prec_q);
  assign last_idx = 2'(c_cnt - 3'd1);

  assign bb_a   = a_q[{i_q, 1'b0} +: 2];
  assign bb_b   = b_q[{j_q, 1'b0} +: 2];
  assign bb_sel = {as_q & (i_q == last_idx), bs_q & (j_q == last_idx)};

  bitbrick u_bitbrick (
    .a   (bb_a),
    .b   (bb_b),
    .sel (bb_sel),
    .p   (bb_p)
  );

  assign p_ext = (bb_sel != 2'b00) ? {{(ACC_W-4){bb_p[3]}}, bb_p}
                                   : {{(ACC_W-4){1'b0}}, bb_p};
  assign shamt = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
  assign term  = p_ext << shamt;
  // A latched clear turns the first crumb pair into a load.
  assign base  = (clr_q && i_q == 2'd0 && j_q == 2'd0) ? '0 : acc_q;

`ifdef BITBRICK_SEQ_MAC_SAT_EN
  logic signed [ACC_W:0] sum_w;
  logic                  sat_q, sat_d;

  assign sum_w = {base[ACC_W-1], base} + {term[ACC_W-1], term};
  assign clip  = sum_w[ACC_W] != sum_w[ACC_W-1];
  assign acc_next = !clip        ? sum_w[ACC_W-1:0] :
                    sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                   {1'b0, {(ACC_W-1){1'b1}}};
  assign sat_flag = sat_q;
`else
  assign acc_next = base + term;
  assign clip     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prec_d  = prec_q;
    as_d    = as_q;
    bs_d    = bs_q;
    clr_d   = clr_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
`ifdef BITBRICK_SEQ_MAC_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          prec_d  = prec;
          as_d    = a_signed;
          bs_d    = b_signed;
          clr_d   = acc_clr;
          i_d     = 2'd0;
          j_d     = 2'd0;
          state_d = ST_RUN;
`ifdef BITBRICK_SEQ_MAC_SAT_EN
          if (acc_clr) sat_d = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        acc_d = acc_next;
`ifdef BITBRICK_SEQ_MAC_SAT_EN
        sat_d = sat_q | clip;
`endif
        // j is the inner loop over b crumbs, i the outer loop over a crumbs.
        if (j_q == last_idx) begin
          j_d = 2'd0;
          if (i_q == last_idx) begin
            i_d     = 2'd0;
            state_d = ST_DONE;
          end else begin
            i_d = i_q + 2'd1;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prec_q  <= PREC_2B;
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      clr_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
`ifdef BITBRICK_SEQ_MAC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prec_q  <= prec_d;
      as_q    <= as_d;
      bs_q    <= bs_d;
      clr_q   <= clr_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
`ifdef BITBRICK_SEQ_MAC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_bitbrick_seq_mac.sv
// Self-checking bench for bitbrick_seq_mac: directed cases plus random operations
// scored against an integer-arithmetic model of the multiply-accumulate.
module tb_bitbrick_seq_mac;

  localparam int ACC_W = 24;

  logic             clk = 1'b0;
  logic             nrst;
  logic             in_valid, in_ready;
  logic [7:0]       a, b;
  logic [1:0]       prec;
  logic             a_signed, b_signed, acc_clr;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] acc_out;
`ifdef BITBRICK_SEQ_MAC_SAT_EN
  logic             sat_flag;
`endif

  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] model_acc;
  logic [ACC_W-1:0] res;
  int               n_checks = 0;
  int               n_fail   = 0;

  bitbrick_seq_mac #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .prec      (prec),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BITBRICK_SEQ_MAC_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Value of the low N bits of v, as an integer, under the given signedness.
  function automatic longint opval(input logic [7:0] v, input logic [1:0] p, input logic s);
    int     n;
    longint x;
    n = (p == 2'd0) ? 2 : (p == 2'd1) ? 4 : 8;
    x = longint'(v) & ((longint'(1) << n) - 1);
    if (s && x[n-1]) x = x - (longint'(1) << n);
    return x;
  endfunction

  function automatic int k_of(input logic [1:0] p);
    int c;
    c = (p == 2'd0) ? 1 : (p == 2'd1) ? 2 : 4;
    return c * c;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected result per completed output handshake.
  always @(negedge clk) begin
    logic [ACC_W-1:0] e;
    if (nrst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: result %0d presented with no expected entry", acc_out);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", acc_out, e);
      end
    end
  end

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] pv,
                        input logic as, input logic bs, input logic clr, input int hold,
                        output logic [ACC_W-1:0] r);
    int     w;
    int     lat;
    longint prod;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("in_ready_before_op", ACC_W'(in_ready), 1);
    a = av; b = bv; prec = pv; a_signed = as; b_signed = bs; acc_clr = clr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); acc_clr = 1'($urandom);
    prod = opval(av, pv, as) * opval(bv, pv, bs);
    model_acc = clr ? ACC_W'(prod) : model_acc + ACC_W'(prod);
    exp_q.push_back(model_acc);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("in_ready_low_in_run", ACC_W'(in_ready), 0);
      tick();
      lat++;
    end
    chk("latency", ACC_W'(lat), ACC_W'(k_of(pv)));
    r = acc_out;
    for (int h = 0; h < hold; h++) begin
      chk("hold_out_valid", ACC_W'(out_valid), 1);
      chk("hold_acc_stable", acc_out, r);
      chk("hold_in_ready_low", ACC_W'(in_ready), 0);
      in_valid = 1'($urandom);
      a = 8'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("in_ready_after_done", ACC_W'(in_ready), 1);
    chk("out_valid_after_done", ACC_W'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; prec = '0; a_signed = 1'b0; b_signed = 1'b0; acc_clr = 1'b0;
    model_acc = '0;
    tick();
    tick();
    chk("reset_in_ready", ACC_W'(in_ready), 1);
    chk("reset_out_valid", ACC_W'(out_valid), 0);
    chk("reset_acc", acc_out, 0);
    nrst = 1'b1;
    tick();

    run_op(8'h03, 8'h02, 2'b00, 1'b0, 1'b0, 1'b1, 0, res);
    chk("t_2b_unsigned", res, 6);
    run_op(8'h80, 8'h7F, 2'b10, 1'b1, 1'b1, 1'b1, 0, res);
    chk("t_8b_signed", res, ACC_W'(-16256));
    run_op(8'h0D, 8'h0F, 2'b01, 1'b1, 1'b0, 1'b1, 1, res);
    chk("t_4b_mixed", res, ACC_W'(-45));
    run_op(8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0, 1'b1, 0, res);
    chk("t_mac_first", res, 65025);
    run_op(8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0, 1'b0, 0, res);
    chk("t_mac_second", res, 130050);
    run_op(8'hF3, 8'hE2, 2'b00, 1'b0, 1'b0, 1'b1, 5, res);
    chk("t_upper_bits_hold", res, 6);
    run_op(8'hFE, 8'hFF, 2'b11, 1'b1, 1'b1, 1'b1, 0, res);
    chk("t_prec11_as_8b", res, 2);

    for (int n = 0; n < 24; n++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), res);
    end

    // Abort an 8b op during its third RUN cycle.
    run_op(8'h7F, 8'h7F, 2'b10, 1'b0, 1'b0, 1'b1, 0, res);
    a = 8'hA5; b = 8'h5A; prec = 2'b10; a_signed = 1'b0; b_signed = 1'b0; acc_clr = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", ACC_W'(in_ready), 0);
    nrst = 1'b0;
    #1;
    chk("midrun_reset_acc", acc_out, 0);
    chk("midrun_reset_out_valid", ACC_W'(out_valid), 0);
    chk("midrun_reset_in_ready", ACC_W'(in_ready), 1);
    model_acc = '0;
    tick();
    nrst = 1'b1;
    tick();
    run_op(8'h03, 8'h03, 2'b00, 1'b0, 1'b0, 1'b0, 0, res);
    chk("post_reset_2b", res, 9);

    repeat (3) tick();
    chk("scoreboard_drained", ACC_W'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitbrick_seq_mac.md
Name: bitbrick_seq_mac

Overview:
- Sequential multi-precision MAC that drives a single bitbrick.
- Splits 2/4/8-bit activation and weight operands into 2-bit crumbs and feeds each crumb pair to one internal bitbrick.
- Shifts each 4-bit partial product and accumulates it.
- This is the producer/consumer end of the bitbrick a/b/sel/p interface; it is the building block for the sparse DNN PE array.

Parameters:
- ACC_W, 24, accumulator width in bits; must be >= 16.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operands (IDLE only).
- a  in  8  activation operand; low N bits used.
- b  in  8  weight operand; low N bits used.
- prec  in  2  precision: 00 = 2b, 01 = 4b, 10 = 8b; 11 is treated as 8b.
- a_signed  in  1  a is two's complement.
- b_signed  in  1  b is two's complement.
- acc_clr  in  1  sampled at accept: zero the accumulator before this product.
- out_valid  out  1  accumulated result valid.
- out_ready  in  1  consumer accepts the result.
- acc_out  out  ACC_W  accumulator value, signed.

Behaviour:
- Reset (asynchronous, nrst low): FSM goes to IDLE; accumulator, counters and out_valid go to 0; in_ready goes to 1.
  - This applies at any time, including mid-RUN; a partial product in flight is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, latch a, b, prec, signs and acc_clr, set crumb indices i = j = 0, go to RUN.
  - RUN: one crumb pair per cycle; j (b crumb) is the inner loop and i (a crumb) the outer loop. C = N/2 crumbs per operand, so K = C*C cycles: 1, 4 or 16. After the last pair, go to DONE.
  - DONE: out_valid = 1, and acc_out holds stable until out_ready. On out_valid & out_ready, go to IDLE; in_ready rises the cycle after.
- Bitbrick drive, per RUN cycle:
  - bb_a = a crumb i, bb_b = b crumb j.
  - sel[1] = a_signed & (i == C-1); sel[0] = b_signed & (j == C-1).
- Partial product handling:
  - p is sign-extended if sel != 00, otherwise zero-extended.
  - It is shifted left by 2*(i+j) and added to the accumulator in the same cycle; the bitbrick is combinational.
  - If acc_clr was latched, the first RUN cycle loads the term instead of adding it.
- Latency: accept at edge T; RUN occupies cycles T+1..T+K; out_valid is high from T+K+1.
- Accumulator persists across operations (MAC). Overflow wraps modulo 2^ACC_W.
- in_valid is ignored outside IDLE; no operand is queued.
- out_ready is ignored unless out_valid is high.
- Operand bits above N are ignored.

Optional Feature:
- Macro: BITBRICK_SEQ_MAC_SAT_EN.
- With the macro defined:
  - Each accumulate saturates to the signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Extra output sat_flag (1 bit), sticky, is set when any add clips. It clears on reset or on an accept with acc_clr = 1.
- Without the macro: wrap-around arithmetic, and no sat_flag port.

Decomposition:
- Package bitbrick_pkg:
  - prec encodings PREC_2B/PREC_4B/PREC_8B.
  - FSM state typedef.
  - crumb-count function C(prec).
- Sub-module: the existing bitbrick, instantiated once; no new sub-module is required.

Test Plan:
- prec = 00, a = 2'b11, b = 2'b10, unsigned, acc_clr = 1 -> one RUN cycle, acc_out = 6, out_valid at T+2.
- prec = 10, a = 0x80, b = 0x7F, both signed, acc_clr = 1 -> 16 RUN cycles with in_ready low throughout, acc_out = -16256.
- prec = 01, a = 4'b1101 signed, b = 4'b1111 unsigned, acc_clr = 1 -> 4 RUN cycles, acc_out = -45.
- Two prec = 10 unsigned ops 255*255, first with acc_clr = 1, second with acc_clr = 0 -> acc_out = 65025, then 130050.
- Hold out_ready = 0 for 5 cycles in DONE -> out_valid and acc_out stable, in_ready = 0, in_valid pulses ignored. Raise out_ready -> in_ready = 1 the next cycle.
- Assert nrst low at the 3rd RUN cycle of an 8b op -> acc_out = 0, out_valid = 0, in_ready = 1 immediately. After release, a fresh 2b op gives the correct product.
